// File: rtl/sw_obj_pkg.sv
// sw_obj_pkg: shared widths, handshake codes and FSM state for the software object table.
package sw_obj_pkg;
  localparam int NUM_WORDS = 16;
  localparam int DATA_W = 32;
  localparam int FC_W = 8;
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [1:0] HS_IDLE = 2'b00;
  localparam logic [1:0] HS_REQ = 2'b01;
  typedef enum logic {IDLE, ACK} state_t;
endpackage

// File: rtl/sw_obj_table_if.sv
// sw_obj_table_if: software mailbox, frame timing and renderer read signals.
interface sw_obj_table_if;
  import sw_obj_pkg::*;
  logic [NUM_WORDS*DATA_W-1:0] hw_words;
  logic [1:0] hw_sig;
  logic [1:0] sw_sig;
  logic frame_start;
  logic [FC_W-1:0] frame_count;
  logic commit;
  logic [IDX_W-1:0] rd_idx;
  logic [DATA_W-1:0] rd_data;
  modport master(output hw_words, hw_sig, frame_start, rd_idx, input sw_sig, frame_count, commit, rd_data);
  modport slave(input hw_words, hw_sig, frame_start, rd_idx, output sw_sig, frame_count, commit, rd_data);
endinterface

// File: rtl/sw_word_bank.sv
// sw_word_bank: word bank with parallel whole-bank load and registered indexed read.
module sw_word_bank #(
  parameter int N = 16,
  parameter int W = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 load,
  input  logic [N*W-1:0]       din,
  input  logic [$clog2(N)-1:0] rd_idx,
  output logic [N*W-1:0]       q,
  output logic [W-1:0]         rd_data
);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q <= '0;
      rd_data <= '0;
    end else begin
      if (load) q <= din;
      rd_data <= q[W*rd_idx +: W];
    end
  end
endmodule

// File: rtl/sw_obj_table.sv
// sw_obj_table: atomic snapshot capture from software, promoted to the active bank at frame start.
module sw_obj_table
  import sw_obj_pkg::*;
(
  input logic Clk,
  input logic Reset,
  sw_obj_table_if.slave bus
);
  state_t state;
  logic pending;
  logic commit_q;
  logic [FC_W-1:0] fc;
  logic [NUM_WORDS*DATA_W-1:0] shadow_q;
  logic [NUM_WORDS*DATA_W-1:0] active_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] unused_shadow_rd;
  logic cap;
  logic do_commit;
  assign cap = (state == IDLE) && (bus.hw_sig == HS_REQ);
  assign do_commit = bus.frame_start && pending;
  sw_word_bank #(.N(NUM_WORDS), .W(DATA_W)) u_shadow (
    .Clk(Clk), .Reset(Reset), .load(cap), .din(bus.hw_words),
    .rd_idx(bus.rd_idx), .q(shadow_q), .rd_data(unused_shadow_rd)
  );
  // Active loads the pre-edge shadow, so a same-cycle capture lands only in shadow.
  sw_word_bank #(.N(NUM_WORDS), .W(DATA_W)) u_active (
    .Clk(Clk), .Reset(Reset), .load(do_commit), .din(shadow_q),
    .rd_idx(bus.rd_idx), .q(active_q), .rd_data(rd_q)
  );
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      pending <= 1'b0;
      commit_q <= 1'b0;
      fc <= '0;
    end else begin
      state <= (state == IDLE) ? ((bus.hw_sig == HS_REQ) ? ACK : IDLE)
                               : ((bus.hw_sig == HS_IDLE) ? IDLE : ACK);
      pending <= cap | (pending & ~bus.frame_start);
      commit_q <= do_commit;
      fc <= fc + FC_W'(bus.frame_start);
    end
  end
  assign bus.sw_sig = {pending, state == ACK};
  assign bus.commit = commit_q;
  assign bus.frame_count = fc;
  assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_sw_obj_table.sv
// tb_sw_obj_table: directed checks of capture, commit, collision, counter wrap and reset.
module tb_sw_obj_table;
  import sw_obj_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int n_commit;
  sw_obj_table_if bus();
  sw_obj_table dut(.Clk(clk), .Reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_words(input logic [31:0] base);
    for (int i = 0; i < NUM_WORDS; i++) bus.hw_words[DATA_W*i +: DATA_W] = base + 32'(i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.hw_sig = HS_IDLE;
    bus.frame_start = 1'b0;
    bus.rd_idx = '0;
    set_words(32'h0);
    step(3);
    chk("rst_sw_sig", 32'(bus.sw_sig), 32'd0);
    chk("rst_fc", 32'(bus.frame_count), 32'd0);
    chk("rst_commit", 32'(bus.commit), 32'd0);
    chk("rst_rd", bus.rd_data, 32'd0);
    reset = 1'b0;
    // capture and commit
    set_words(32'hA000_0000);
    bus.hw_sig = HS_REQ;
    step(1);
    chk("cap_ack", 32'(bus.sw_sig), 32'd3);
    bus.hw_sig = HS_IDLE;
    bus.rd_idx = 4'd5;
    step(1);
    chk("drop_ack", 32'(bus.sw_sig), 32'd2);
    chk("pre_commit_rd", bus.rd_data, 32'd0);
    bus.frame_start = 1'b1;
    step(1);
    chk("commit_pulse", 32'(bus.commit), 32'd1);
    chk("commit_pend_clr", 32'(bus.sw_sig), 32'd0);
    chk("commit_fc", 32'(bus.frame_count), 32'd1);
    chk("commit_rd_old", bus.rd_data, 32'd0);
    bus.frame_start = 1'b0;
    step(1);
    chk("commit_low", 32'(bus.commit), 32'd0);
    chk("rd_idx5", bus.rd_data, 32'hA000_0005);
    // no commit without a frame boundary
    set_words(32'hB000_0000);
    bus.hw_sig = HS_REQ;
    step(1);
    chk("cap2_ack", 32'(bus.sw_sig), 32'd3);
    bus.hw_sig = HS_IDLE;
    for (int c = 0; c < 100; c++) begin
      step(1);
      chk("hold_pend", 32'(bus.sw_sig[1]), 32'd1);
      chk("hold_rd", bus.rd_data, 32'hA000_0005);
    end
    // held request: only the first-cycle words are captured
    set_words(32'hC000_0000);
    bus.hw_sig = HS_REQ;
    for (int c = 1; c < 20; c++) begin
      step(1);
      set_words(32'hD000_0000 + 32'(c * 16));
    end
    step(1);
    chk("held_ack", 32'(bus.sw_sig), 32'd3);
    bus.hw_sig = HS_IDLE;
    bus.frame_start = 1'b1;
    step(1);
    chk("held_commit", 32'(bus.commit), 32'd1);
    chk("held_fc", 32'(bus.frame_count), 32'd2);
    bus.frame_start = 1'b0;
    bus.rd_idx = 4'd3;
    step(1);
    chk("held_rd3", bus.rd_data, 32'hC000_0003);
    bus.rd_idx = 4'd15;
    step(1);
    chk("held_rd15", bus.rd_data, 32'hC000_000F);
    // collision with pending set
    set_words(32'hE000_0000);
    bus.hw_sig = HS_REQ;
    step(1);
    bus.hw_sig = HS_IDLE;
    step(1);
    chk("coll_pend", 32'(bus.sw_sig), 32'd2);
    set_words(32'hF000_0000);
    bus.hw_sig = HS_REQ;
    bus.frame_start = 1'b1;
    step(1);
    chk("coll_commit", 32'(bus.commit), 32'd1);
    chk("coll_sw_sig", 32'(bus.sw_sig), 32'd3);
    chk("coll_fc", 32'(bus.frame_count), 32'd3);
    bus.hw_sig = HS_IDLE;
    bus.frame_start = 1'b0;
    bus.rd_idx = 4'd7;
    step(1);
    chk("coll_rd_old", bus.rd_data, 32'hE000_0007);
    chk("coll_still_pend", 32'(bus.sw_sig), 32'd2);
    bus.frame_start = 1'b1;
    step(1);
    chk("coll2_commit", 32'(bus.commit), 32'd1);
    bus.frame_start = 1'b0;
    step(1);
    chk("coll2_rd_new", bus.rd_data, 32'hF000_0007);
    chk("coll2_sw_sig", 32'(bus.sw_sig), 32'd0);
    // collision with pending clear: capture only
    set_words(32'h1000_0000);
    bus.hw_sig = HS_REQ;
    bus.frame_start = 1'b1;
    step(1);
    chk("coll0_commit", 32'(bus.commit), 32'd0);
    chk("coll0_sw_sig", 32'(bus.sw_sig), 32'd3);
    chk("coll0_fc", 32'(bus.frame_count), 32'd5);
    bus.hw_sig = HS_IDLE;
    bus.frame_start = 1'b0;
    step(1);
    chk("coll0_drop", 32'(bus.sw_sig), 32'd2);
    // frame counter wrap: 256 pulses from 5, only the first commits
    n_commit = 0;
    for (int p = 0; p < 256; p++) begin
      bus.frame_start = 1'b1;
      step(1);
      n_commit += int'(bus.commit);
      if (p == 250) chk("fc_wrap0", 32'(bus.frame_count), 32'd0);
      bus.frame_start = 1'b0;
      step(1);
    end
    chk("wrap_fc", 32'(bus.frame_count), 32'd5);
    chk("wrap_commits", 32'(n_commit), 32'd1);
    chk("wrap_rd", bus.rd_data, 32'h1000_0007);
    // reset while in ACK with request held
    set_words(32'h2000_0000);
    bus.hw_sig = HS_REQ;
    step(1);
    chk("pre_rst_ack", 32'(bus.sw_sig), 32'd3);
    reset = 1'b1;
    step(1);
    chk("rst_ack_sw", 32'(bus.sw_sig), 32'd0);
    chk("rst_ack_fc", 32'(bus.frame_count), 32'd0);
    chk("rst_ack_commit", 32'(bus.commit), 32'd0);
    chk("rst_ack_rd", bus.rd_data, 32'd0);
    set_words(32'h3000_0000);
    reset = 1'b0;
    step(1);
    chk("recap_ack", 32'(bus.sw_sig), 32'd3);
    bus.hw_sig = HS_IDLE;
    bus.frame_start = 1'b1;
    step(1);
    chk("recap_commit", 32'(bus.commit), 32'd1);
    bus.frame_start = 1'b0;
    step(1);
    chk("recap_rd", bus.rd_data, 32'h3000_0007);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
